// File: rtl/dmem_lanes.sv
// Data memory for the MIPS datapath: byte/half/word stores and extending loads behind a
// one-outstanding req/ready handshake, with configurable read latency and a sticky fault register.
module dmem_lanes #(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic        rerr,
    output logic        fault,
    output logic [31:0] fault_addr,
    input  logic        fault_clr
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'(RD_LAT - 1);

    typedef enum logic {StIdle, StWait} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        accept;
    logic        finish;

    logic [31:0] mem [DEPTH];
    logic [AW-1:0] idx;
    logic        size_bad;
    logic        range_bad;
    logic        flt;
    logic [3:0]  be;
    logic [31:0] wlane;
    logic [31:0] rword;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic [31:0] ld_res;

    logic [31:0] pend_q;
    logic        pend_err_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic        rerr_q;
    logic        fault_q;
    logic [31:0] fault_addr_q;

    assign idx       = addr[AW+1:2];
    assign range_bad = |addr[31:AW+2];
    assign flt       = size_bad | range_bad;
    assign accept    = req & ready;

    // Alignment check and lane decode for the current request.
    always_comb begin
        size_bad = 1'b0;
        be       = 4'b0000;
        wlane    = wdata;
        unique case (size)
            2'b00: begin
                be    = 4'b0001 << addr[1:0];
                wlane = {4{wdata[7:0]}};
            end
            2'b01: begin
                size_bad = addr[0];
                be       = addr[1] ? 4'b1100 : 4'b0011;
                wlane    = {2{wdata[15:0]}};
            end
            2'b10: begin
                size_bad = (addr[1:0] != 2'b00);
                be       = 4'b1111;
            end
            default: begin
                size_bad = 1'b1;
            end
        endcase
    end

    // Lane select and extension of the addressed word; faulting loads return zero.
    always_comb begin
        rword  = mem[idx];
        rbyte  = rword[{addr[1:0], 3'b000} +: 8];
        rhalf  = rword[{addr[1], 4'b0000} +: 16];
        ld_res = rword;
        unique case (size)
            2'b00:   ld_res = {{24{sext & rbyte[7]}}, rbyte};
            2'b01:   ld_res = {{16{sext & rhalf[15]}}, rhalf};
            default: ld_res = rword;
        endcase
        if (flt) begin
            ld_res = 32'h0;
        end
    end

    // Array is deliberately not reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (accept && we && !flt) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) begin
                    mem[idx][8*k +: 8] <= wlane[8*k +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        finish  = 1'b0;
        ready   = rst_n && (state_q == StIdle);
        unique case (state_q)
            StIdle: begin
                if (accept && !we && (RD_LAT > 1)) begin
                    state_d = StWait;
                    cnt_d   = CNT_INIT;
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = StIdle;
                    finish  = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            pend_q       <= 32'h0;
            pend_err_q   <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= 32'h0;
            rerr_q       <= 1'b0;
            fault_q      <= 1'b0;
            fault_addr_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= 1'b0;
            if (accept && !we) begin
                if (RD_LAT == 1) begin
                    rvalid_q <= 1'b1;
                    rdata_q  <= ld_res;
                    rerr_q   <= flt;
                end else begin
                    pend_q     <= ld_res;
                    pend_err_q <= flt;
                end
            end
            if (finish) begin
                rvalid_q <= 1'b1;
                rdata_q  <= pend_q;
                rerr_q   <= pend_err_q;
            end
            // A new fault beats a simultaneous clear; otherwise the first fault address is kept.
            if (accept && flt) begin
                fault_q <= 1'b1;
                if (!fault_q || fault_clr) begin
                    fault_addr_q <= addr;
                end
            end else if (fault_clr) begin
                fault_q      <= 1'b0;
                fault_addr_q <= 32'h0;
            end
        end
    end

    assign rvalid     = rvalid_q;
    assign rdata      = rdata_q;
    assign rerr       = rerr_q;
    assign fault      = fault_q;
    assign fault_addr = fault_addr_q;

endmodule

// File: tb/tb_dmem_lanes.sv
// Bench for dmem_lanes: five instances (RD_LAT 1,2,3,4,8) share stimulus; one is observed at a
// time, with a byte-array model feeding a scoreboard of expected load results and cycles.
module tb_dmem_lanes;

    localparam int NDUT = 5;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        fault_clr;

    logic        ready_a      [NDUT];
    logic        rvalid_a     [NDUT];
    logic [31:0] rdata_a      [NDUT];
    logic        rerr_a       [NDUT];
    logic        fault_a      [NDUT];
    logic [31:0] fault_addr_a [NDUT];

    logic [2:0]  sel;
    logic        ready_m, rvalid_m, rerr_m, fault_m;
    logic [31:0] rdata_m, fault_addr_m;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        dmem_lanes #(
            .DEPTH  (64),
            .RD_LAT (g == 0 ? 1 : g == 1 ? 2 : g == 2 ? 3 : g == 3 ? 4 : 8)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .req        (req),
            .we         (we),
            .size       (size),
            .sext       (sext),
            .addr       (addr),
            .wdata      (wdata),
            .ready      (ready_a[g]),
            .rvalid     (rvalid_a[g]),
            .rdata      (rdata_a[g]),
            .rerr       (rerr_a[g]),
            .fault      (fault_a[g]),
            .fault_addr (fault_addr_a[g]),
            .fault_clr  (fault_clr)
        );
    end

    assign ready_m      = ready_a[sel];
    assign rvalid_m     = rvalid_a[sel];
    assign rdata_m      = rdata_a[sel];
    assign rerr_m       = rerr_a[sel];
    assign fault_m      = fault_a[sel];
    assign fault_addr_m = fault_addr_a[sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tot = 0;
    int bad = 0;

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          c;
    } exp_t;
    exp_t sbq[$];

    logic [7:0]  mm [256];
    logic        m_fault;
    logic [31:0] m_faddr;
    int          last_acc;
    int          last_waits;

    function automatic int lat_of(input logic [2:0] s);
        case (s)
            3'd0:    return 1;
            3'd1:    return 2;
            3'd2:    return 3;
            3'd3:    return 4;
            default: return 8;
        endcase
    endfunction

    function automatic bit m_flt(input logic [31:0] a, input logic [1:0] sz);
        return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00) ||
               (a >= 32'd256);
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] sz,
                                           input bit sx);
        logic [7:0]  b;
        logic [15:0] h;
        case (sz)
            2'b00: begin
                b = mm[a[7:0]];
                return {{24{sx & b[7]}}, b};
            end
            2'b01: begin
                h = {mm[a[7:0] + 8'd1], mm[a[7:0]]};
                return {{16{sx & h[15]}}, h};
            end
            default: return {mm[a[7:0] + 8'd3], mm[a[7:0] + 8'd2], mm[a[7:0] + 8'd1], mm[a[7:0]]};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tot++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every rvalid must match the oldest outstanding load, in its cycle.
    always @(negedge clk) begin
        if (rst_n && rvalid_m) begin
            if (sbq.size() == 0) begin
                chk("spurious_rvalid", {31'h0, rvalid_m}, 32'h0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("rdata", rdata_m, e.d);
                chk("rerr", {31'h0, rerr_m}, {31'h0, e.e});
                chk("rvalid_cycle", cyc, e.c);
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input bit w, input logic [1:0] sz, input bit sx, input logic [31:0] a,
                         input logic [31:0] wd, input bit clr, input bit dir,
                         input logic [31:0] dexp);
        bit   f;
        exp_t e;
        req = 1'b1; we = w; size = sz; sext = sx; addr = a; wdata = wd; fault_clr = clr;
        last_waits = 0;
        @(negedge clk);
        while (!ready_m && last_waits < 40) begin
            last_waits++;
            @(negedge clk);
        end
        if (!ready_m) begin
            chk("accept_timeout", {31'h0, ready_m}, 32'h1);
            req = 1'b0; fault_clr = 1'b0;
            return;
        end
        last_acc = cyc;
        f = m_flt(a, sz);
        if (f) begin
            if (!m_fault || clr) m_faddr = a;
            m_fault = 1'b1;
        end else if (clr) begin
            m_fault = 1'b0;
            m_faddr = 32'h0;
        end
        if (w && !f) begin
            case (sz)
                2'b00: mm[a[7:0]] = wd[7:0];
                2'b01: begin
                    mm[a[7:0]] = wd[7:0]; mm[a[7:0] + 8'd1] = wd[15:8];
                end
                default: begin
                    mm[a[7:0]] = wd[7:0]; mm[a[7:0] + 8'd1] = wd[15:8];
                    mm[a[7:0] + 8'd2] = wd[23:16]; mm[a[7:0] + 8'd3] = wd[31:24];
                end
            endcase
        end
        if (!w) begin
            e.d = dir ? dexp : (f ? 32'h0 : m_load(a, sz, sx));
            e.e = f;
            e.c = last_acc + lat_of(sel);
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        req = 1'b0; fault_clr = 1'b0;
    endtask

    task automatic st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        issue(1'b1, sz, 1'b0, a, wd, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic ld(input logic [1:0] sz, input bit sx, input logic [31:0] a,
                      input logic [31:0] dexp);
        issue(1'b0, sz, sx, a, 32'h0, 1'b0, 1'b1, dexp);
    endtask

    task automatic drain();
        int g = 0;
        while (sbq.size() != 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("drain", sbq.size(), 32'h0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_fault(input string tag);
        @(negedge clk);
        chk({tag, "_fault"}, {31'h0, fault_m}, {31'h0, m_fault});
        chk({tag, "_faddr"}, fault_addr_m, m_faddr);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = 1'b0; fault_clr = 1'b0;
        sbq.delete();
        m_fault = 1'b0; m_faddr = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'h0, ready_m}, 32'h0);
        chk("rst_rvalid", {31'h0, rvalid_m}, 32'h0);
        chk("rst_rdata", rdata_m, 32'h0);
        chk("rst_rerr", {31'h0, rerr_m}, 32'h0);
        chk("rst_fault", {31'h0, fault_m}, 32'h0);
        chk("rst_faddr", fault_addr_m, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'h0, ready_m}, 32'h1);
        @(posedge clk);
        #1;
    endtask

    task automatic rand_phase(input logic [2:0] s, input int nops);
        logic [31:0] a;
        logic [1:0]  sz;
        int          r;
        sel = s;
        do_reset();
        for (int i = 0; i < 64; i++) st(2'b10, 32'(i * 4), $urandom);
        for (int i = 0; i < nops; i++) begin
            r  = $urandom_range(0, 9);
            sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            a  = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b01) a[0] = 1'b0;
                if (sz == 2'b10) a[1:0] = 2'b00;
            end
            if ($urandom_range(0, 19) == 0) a = 32'(256 + $urandom_range(0, 1000));
            issue($urandom_range(0, 2) == 0, sz, 1'($urandom_range(0, 1)), a, $urandom,
                  1'b0, 1'b0, 32'h0);
        end
        drain();
        check_fault("rand");
    endtask

    initial begin
        int n;
        rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; sext = 1'b0;
        addr = 32'h0; wdata = 32'h0; fault_clr = 1'b0; sel = 3'd0;
        m_fault = 1'b0; m_faddr = 32'h0;
        @(posedge clk);
        #1;

        // RD_LAT=1: basic word and sub-word accesses
        do_reset();
        st(2'b10, 32'h10, 32'h8765_4321);
        ld(2'b10, 1'b0, 32'h10, 32'h8765_4321);
        n = last_acc;
        ld(2'b00, 1'b1, 32'h13, 32'hFFFF_FF87);
        chk("b2b_accept", last_acc, n + 1);
        ld(2'b00, 1'b0, 32'h13, 32'h0000_0087);
        ld(2'b01, 1'b1, 32'h10, 32'h0000_4321);
        ld(2'b01, 1'b0, 32'h12, 32'h0000_8765);
        st(2'b00, 32'h11, 32'h0000_00AA);
        ld(2'b10, 1'b0, 32'h10, 32'h8765_AA21);
        drain();
        check_fault("clean");

        // Faults
        st(2'b10, 32'h0, 32'h1122_3344);
        ld(2'b10, 1'b0, 32'h12, 32'h0);
        drain();
        check_fault("lw_mis");
        st(2'b10, 32'h400, 32'hDEAD_BEEF);
        check_fault("sw_range");
        ld(2'b10, 1'b0, 32'h0, 32'h1122_3344);
        drain();
        issue(1'b1, 2'b01, 1'b0, 32'h21, 32'hFFFF, 1'b1, 1'b0, 32'h0);
        check_fault("clr_and_new");
        fault_clr = 1'b1;
        m_fault = 1'b0; m_faddr = 32'h0;
        @(posedge clk);
        #1;
        fault_clr = 1'b0;
        check_fault("clr_only");

        // RD_LAT=3: held request is not accepted until the rvalid cycle
        sel = 3'd2;
        do_reset();
        st(2'b10, 32'h40, 32'hCAFE_F00D);
        ld(2'b10, 1'b0, 32'h40, 32'hCAFE_F00D);
        n = last_acc;
        ld(2'b01, 1'b1, 32'h42, 32'hFFFF_CAFE);
        chk("lat3_waits", last_waits, 32'd2);
        chk("lat3_accept", last_acc, n + 3);
        drain();

        // RD_LAT=4: reset two cycles after a load abandons it; memory survives
        sel = 3'd3;
        do_reset();
        st(2'b10, 32'h20, 32'h1357_9BDF);
        ld(2'b10, 1'b0, 32'h20, 32'h1357_9BDF);
        @(posedge clk);
        #1;
        do_reset();
        repeat (10) @(posedge clk);
        #1;
        ld(2'b10, 1'b0, 32'h20, 32'h1357_9BDF);
        drain();

        // Random traffic against the model
        rand_phase(3'd1, 200);
        rand_phase(3'd0, 200);
        rand_phase(3'd4, 120);

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule

// File: doc/dmem_lanes.md
Name: dmem_lanes

Overview:
Parametrised data memory for the MIPS datapath, successor to the single-cycle word-only data memory. Adds byte/halfword/word stores and loads with sign or zero extension, and a configurable registered read latency behind a one-outstanding req/ready handshake. Misaligned and out-of-range accesses are detected and reported through a sticky fault register. Sits between the execute/memory stage and the register-file writeback mux.

Parameters:
DEPTH, 64, number of 32-bit words; power of two, 4..65536
RD_LAT, 1, read latency in cycles from acceptance to rvalid; 1..8

Ports:
clk  input  1  single clock; all state on rising edge
rst_n  input  1  synchronous active-low reset
req  input  1  access request; accepted when req && ready
we  input  1  1 = store, 0 = load; sampled at acceptance
size  input  2  00 byte, 01 halfword, 10 word, 11 illegal
sext  input  1  loads: 1 sign-extend, 0 zero-extend; ignored for word and stores
addr  input  32  byte address
wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
ready  output  1  block can accept a request this cycle
rvalid  output  1  one-cycle pulse: load result valid
rdata  output  32  load result, extended to 32 bits
rerr  output  1  qualifies rvalid: load faulted, rdata forced 0
fault  output  1  sticky: a faulting access has been accepted
fault_addr  output  32  address of first faulting access since last clear
fault_clr  input  1  clears fault and fault_addr

Behaviour:
- Reset (rst_n=0 at an edge): ready=0 during reset, 1 from first cycle after release; rvalid=0, rdata=0, rerr=0, fault=0, fault_addr=0, FSM to IDLE. Memory array NOT reset; contents survive reset.
- Reset mid-load: in-flight load abandoned, no rvalid ever issued for it.
- Little-endian lanes: byte at addr[1:0]=k occupies bits [8k+7:8k]; halfword at addr[1]=h occupies [16h+15:16h]. Word index = addr[log2(DEPTH)+1:2].
- Fault conditions (checked at acceptance): size=11; halfword with addr[0]=1; word with addr[1:0]!=0; addr >= 4*DEPTH. Faulting access: no array write; fault set; fault_addr loaded only if fault was 0 (first fault kept).
- fault_clr and new fault in same cycle: new fault wins; fault=1, fault_addr = new address.
- Store: array updated at accepting edge, only addressed lanes written (sb one lane, sh two lanes, sw all four); no rvalid; ready stays 1.
- Load: array read at accepting edge into a data register; lane selected and extended; result presented RD_LAT cycles after acceptance.
- FSM: IDLE (ready=1) -> on accepted load with RD_LAT>1 -> WAIT (ready=0, down-counter loaded RD_LAT-1) -> counter reaches 0 -> IDLE. With RD_LAT=1 WAIT never entered; back-to-back loads every cycle.
- Timing: load accepted in cycle n -> rvalid=1 for exactly cycle n+RD_LAT; ready low in cycles n+1..n+RD_LAT-1 and high in cycle n+RD_LAT, so the next request may be accepted in the rvalid cycle.
- rdata/rerr hold their last value when rvalid=0; only sampled when rvalid=1.
- Faulting load: still completes with normal latency; rvalid=1, rerr=1, rdata=0.
- Store accepted in cycle n followed by load of same word in cycle n+1 returns stored data (no read-before-write hazard).
- req while ready=0: ignored, no state change; requester must hold.

Test Plan:
- Reset release, RD_LAT=1: sw 0x8765_4321 to 0x10, lw 0x10 next cycle -> rvalid cycle after acceptance, rdata=0x8765_4321, rerr=0, fault=0.
- Sub-word: after above, lb 0x13 sext=1 -> 0xFFFF_FF87; lbu 0x13 -> 0x0000_0087; lh 0x10 sext=1 -> 0x0000_4321; lhu 0x12 -> 0x0000_8765; sb 0x11 wdata=0xAA then lw 0x10 -> 0x8765_AA21.
- RD_LAT=3: load accepted cycle 5 -> ready=0 cycles 6-7, rvalid=1 only cycle 8; req held high cycles 6-7 not accepted; second load accepted cycle 8.
- Faults: lw 0x12 -> rvalid, rerr=1, rdata=0, fault=1, fault_addr=0x12; then sw 0x400 (DEPTH=64) -> no write, fault_addr stays 0x12; fault_clr together with sh 0x21 -> fault=1, fault_addr=0x21.
- Reset mid-read, RD_LAT=4: load accepted, rst_n=0 two cycles later -> no rvalid; memory word previously written still reads back after reset.
- Random mixed byte/half/word stores and loads against a byte-array reference model over all addresses of DEPTH=64, RD_LAT in {1,2,8} -> zero mismatches.
